expected_delay: RTL and testbench

// - Verification helper: delays an expected-value word and its valid flag by exactly LATENCY
//   cke-qualified clock cycles.
// - Lets SVA checkers compare a pipelined DUT output against a golden value computed on the

---
 rtl/expected_delay_pkg.sv | 7 +
 rtl/expected_delay_stage.sv | 42 ++++
 rtl/expected_delay.sv | 49 ++++
 tb/tb_expected_delay.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/expected_delay_pkg.sv
// Shared defaults for the expected-value delay line.
package expected_delay_pkg;

  localparam int unsigned DEFAULT_LATENCY       = 1;
  localparam int unsigned DEFAULT_EXPECTED_BITS = 8;

endpackage : expected_delay_pkg

// File: rtl/expected_delay_stage.sv
// One slice of the delay line: a valid flag plus a data word that loads only when valid.
module expected_delay_stage #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cke,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data
);

  logic             valid_d, valid_q;
  logic [WIDTH-1:0] data_d,  data_q;

  // Data only moves alongside a valid flag, so undefined words behind a bubble never enter.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (cke) begin
      valid_d = in_valid;
      if (in_valid) begin
        data_d = in_data;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;

endmodule : expected_delay_stage

// File: rtl/expected_delay.sv
// Delays an expected-value word and its valid flag by LATENCY clock-enabled cycles.
module expected_delay
  import expected_delay_pkg::*;
#(
  parameter int unsigned LATENCY       = DEFAULT_LATENCY,
  parameter int unsigned EXPECTED_BITS = DEFAULT_EXPECTED_BITS
) (
  input  logic                     reset,
  input  logic                     clk,
  input  logic                     cke,
  input  logic [EXPECTED_BITS-1:0] s_data,
  input  logic                     s_valid,
  output logic [EXPECTED_BITS-1:0] m_data,
  output logic                     m_valid
);

  if (LATENCY == 0) begin : g_bypass
    assign m_data  = s_data;
    assign m_valid = s_valid;

    // Clock, reset and enable are irrelevant without storage.
    logic unused_c;
    assign unused_c = ^{clk, reset, cke};
  end else begin : g_pipe
    logic [LATENCY:0]         valid_chain;
    logic [EXPECTED_BITS-1:0] data_chain [LATENCY+1];

    assign valid_chain[0] = s_valid;
    assign data_chain[0]  = s_data;

    for (genvar i = 0; i < LATENCY; i++) begin : g_stage
      expected_delay_stage #(
        .WIDTH (EXPECTED_BITS)
      ) u_stage (
        .clk       (clk),
        .reset     (reset),
        .cke       (cke),
        .in_valid  (valid_chain[i]),
        .in_data   (data_chain[i]),
        .out_valid (valid_chain[i+1]),
        .out_data  (data_chain[i+1])
      );
    end

    assign m_data  = data_chain[LATENCY];
    assign m_valid = valid_chain[LATENCY];
  end

endmodule : expected_delay

// File: tb/tb_expected_delay.sv
// Directed bench: several delay-line configurations sharing one stimulus stream.
module tb_expected_delay;

  logic        clk;
  logic        reset;
  logic        cke;
  logic [32:0] s_data;
  logic        s_valid;

  logic [7:0]  m_data0, m_data1, m_data2, m_data5;
  logic [32:0] m_data3;
  logic [0:0]  m_dataw1;
  logic        m_valid0, m_valid1, m_valid2, m_valid3, m_valid5, m_validw1;

  int n_cmp  = 0;
  int n_fail = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  expected_delay #(.LATENCY(0), .EXPECTED_BITS(8)) u_l0 (
    .reset(reset), .clk(clk), .cke(cke), .s_data(s_data[7:0]), .s_valid(s_valid),
    .m_data(m_data0), .m_valid(m_valid0));
  expected_delay #(.LATENCY(1), .EXPECTED_BITS(8)) u_l1 (
    .reset(reset), .clk(clk), .cke(cke), .s_data(s_data[7:0]), .s_valid(s_valid),
    .m_data(m_data1), .m_valid(m_valid1));
  expected_delay #(.LATENCY(2), .EXPECTED_BITS(8)) u_l2 (
    .reset(reset), .clk(clk), .cke(cke), .s_data(s_data[7:0]), .s_valid(s_valid),
    .m_data(m_data2), .m_valid(m_valid2));
  expected_delay #(.LATENCY(3), .EXPECTED_BITS(33)) u_l3 (
    .reset(reset), .clk(clk), .cke(cke), .s_data(s_data), .s_valid(s_valid),
    .m_data(m_data3), .m_valid(m_valid3));
  expected_delay #(.LATENCY(5), .EXPECTED_BITS(8)) u_l5 (
    .reset(reset), .clk(clk), .cke(cke), .s_data(s_data[7:0]), .s_valid(s_valid),
    .m_data(m_data5), .m_valid(m_valid5));
  expected_delay #(.LATENCY(2), .EXPECTED_BITS(1)) u_w1 (
    .reset(reset), .clk(clk), .cke(cke), .s_data(s_data[0:0]), .s_valid(s_valid),
    .m_data(m_dataw1), .m_valid(m_validw1));

  task automatic chk(input string tag, input logic [32:0] obs, input logic [32:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just past the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  localparam logic [32:0] ITEM_A = 33'h1_2345_6789;
  localparam logic [32:0] ITEM_B = 33'h0_DEAD_BEEF;
  localparam logic [32:0] ITEM_C = 33'h1_0000_0003;
  localparam logic [32:0] ITEM_D = 33'h0_CAFE_F00D;

  initial begin
    int j;
    int valid_cnt;
    logic [32:0] exp_d;

    reset   = 1'b0;
    cke     = 1'b1;
    s_valid = 1'b0;
    s_data  = '0;
    #1;
    // Reset state: no clock edge has happened yet.
    chk("rst_v1", 33'(m_valid1), 33'd0);
    chk("rst_d1", 33'(m_data1),  33'd0);
    chk("rst_v2", 33'(m_valid2), 33'd0);
    chk("rst_v3", 33'(m_valid3), 33'd0);
    chk("rst_d3", m_data3,       33'd0);
    chk("rst_v5", 33'(m_valid5), 33'd0);
    chk("rst_d5", 33'(m_data5),  33'd0);
    chk("rst_dw1", 33'(m_dataw1), 33'd0);
    chk("rst_d0", 33'(m_data0),  33'd0);
    step();
    step();
    chk("rst_hold_v1", 33'(m_valid1), 33'd0);

    // Scenario 1: single item through LATENCY=1 and 2.
    reset   = 1'b1;
    s_data  = 33'h5A;
    s_valid = 1'b1;
    step();
    s_valid = 1'b0;
    s_data  = 'x;
    chk("s1_v1_a", 33'(m_valid1), 33'd1);
    chk("s1_d1_a", 33'(m_data1),  33'h5A);
    chk("s1_v2_a", 33'(m_valid2), 33'd0);
    chk("s1_d2_a", 33'(m_data2),  33'h00);
    step();
    chk("s1_v1_b", 33'(m_valid1), 33'd0);
    chk("s1_d1_b", 33'(m_data1),  33'h5A);
    chk("s1_v2_b", 33'(m_valid2), 33'd1);
    chk("s1_d2_b", 33'(m_data2),  33'h5A);
    step();
    chk("s1_v2_c", 33'(m_valid2), 33'd0);
    chk("s1_d2_c", 33'(m_data2),  33'h5A);
    for (int k = 0; k < 6; k++) step();
    chk("s6_d5_idle", 33'(m_data5), 33'h5A);

    // Scenario 2: eight back-to-back items, X data in the gaps.
    valid_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      s_valid = (i < 8);
      s_data  = (i < 8) ? 33'(i + 1) : 'x;
      step();
      j = i - 4;
      exp_d = (j < 0) ? 33'h5A : ((j > 7) ? 33'h08 : 33'(j + 1));
      if (m_valid5) valid_cnt++;
      chk($sformatf("s2_v5_%0d", i), 33'(m_valid5), 33'((j >= 0) && (j <= 7)));
      chk($sformatf("s2_d5_%0d", i), 33'(m_data5), exp_d);
      j = i - 1;
      exp_d = ((j >= 0) && (j <= 7)) ? 33'((j + 1) % 2) : 33'd0;
      chk($sformatf("s2_dw1_%0d", i), 33'(m_dataw1), exp_d);
    end
    chk("s2_v5_count", 33'(valid_cnt), 33'd8);

    // Scenario 3: LATENCY=2 with a three-cycle enable gap.
    s_valid = 1'b1;
    s_data  = 33'h11;
    step();
    s_valid = 1'b0;
    s_data  = 'x;
    cke     = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("s3_gap_v_%0d", k), 33'(m_valid2), 33'd0);
      chk($sformatf("s3_gap_d_%0d", k), 33'(m_data2),  33'h08);
    end
    cke     = 1'b1;
    s_valid = 1'b1;
    s_data  = 33'h22;
    step();
    chk("s3_v_11", 33'(m_valid2), 33'd1);
    chk("s3_d_11", 33'(m_data2),  33'h11);
    s_valid = 1'b0;
    s_data  = 'x;
    cke     = 1'b0;
    step();
    chk("s3_hold_v", 33'(m_valid2), 33'd1);
    chk("s3_hold_d", 33'(m_data2),  33'h11);
    cke = 1'b1;
    step();
    chk("s3_v_22", 33'(m_valid2), 33'd1);
    chk("s3_d_22", 33'(m_data2),  33'h22);
    step();
    chk("s3_v_end", 33'(m_valid2), 33'd0);
    chk("s3_d_end", 33'(m_data2),  33'h22);
    for (int k = 0; k < 4; k++) step();

    // Scenario 5: LATENCY=3, 33-bit, reset pulsed mid-stream between edges.
    s_valid = 1'b1;
    s_data  = ITEM_A;
    step();
    s_data  = ITEM_B;
    step();
    s_data  = ITEM_C;
    step();
    chk("s5_v3_full", 33'(m_valid3), 33'd1);
    chk("s5_d3_full", m_data3,       ITEM_A);
    s_valid = 1'b0;
    s_data  = 'x;
    #2 reset = 1'b0;
    #1;
    chk("s5_v3_rst", 33'(m_valid3), 33'd0);
    chk("s5_d3_rst", m_data3,       33'd0);
    chk("s5_d5_rst", 33'(m_data5),  33'd0);
    #1 reset = 1'b1;
    s_valid = 1'b1;
    s_data  = ITEM_D;
    step();
    s_valid = 1'b0;
    s_data  = 'x;
    chk("s5_v3_p1", 33'(m_valid3), 33'd0);
    step();
    chk("s5_v3_p2", 33'(m_valid3), 33'd0);
    chk("s5_d3_p2", m_data3,       33'd0);
    step();
    chk("s5_v3_out", 33'(m_valid3), 33'd1);
    chk("s5_d3_out", m_data3,       ITEM_D);

    // Scenario 4: LATENCY=0 pass-through under random reset/cke.
    for (int k = 0; k < 12; k++) begin
      s_data  = 33'($urandom);
      s_valid = 1'($urandom_range(1, 0));
      reset   = 1'($urandom_range(1, 0));
      cke     = 1'($urandom_range(1, 0));
      #3;
      chk($sformatf("s4_d0_%0d", k), 33'(m_data0),  33'(s_data[7:0]));
      chk($sformatf("s4_v0_%0d", k), 33'(m_valid0), 33'(s_valid));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule : tb_expected_delay
